// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode encodings, FSM state encoding and a
// parity-enable helper used by both the TX and RX state machines.
package uart_pkg;

    // par_mode encodings (00 and 11 both mean no parity bit)
    localparam logic [1:0] PAR_NONE     = 2'b00;
    localparam logic [1:0] PAR_EVEN     = 2'b01;
    localparam logic [1:0] PAR_ODD      = 2'b10;
    localparam logic [1:0] PAR_NONE_ALT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    function automatic logic par_on(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/fifo.sv
// Synchronous FIFO, depth 2**ADDR_W, first-word-fall-through read port.
// Ports: clk, reset (sync, active-high), rd/wr strobes, w_data in,
//        r_data (head word, combinational), empty, full.
// Read+write on full succeeds; read+write on empty performs only the write.
module fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic [DATA_W-1:0] w_data,
    output logic              empty,
    output logic              full,
    output logic [DATA_W-1:0] r_data
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
    logic [ADDR_W-1:0] w_succ, r_succ;
    logic              full_q, full_d, empty_q, empty_d;
    logic              do_wr, do_rd;

    // Pointer/flag update
    always_comb begin
        do_wr   = wr & (~full_q | rd);
        do_rd   = rd & ~empty_q;
        w_succ  = w_ptr_q + ADDR_W'(1);
        r_succ  = r_ptr_q + ADDR_W'(1);
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        full_d  = full_q;
        empty_d = empty_q;
        case ({do_wr, do_rd})
            2'b01: begin
                r_ptr_d = r_succ;
                full_d  = 1'b0;
                empty_d = (r_succ == w_ptr_q);
            end
            2'b10: begin
                w_ptr_d = w_succ;
                empty_d = 1'b0;
                full_d  = (w_succ == r_ptr_q);
            end
            2'b11: begin
                w_ptr_d = w_succ;
                r_ptr_d = r_succ;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Storage needs no reset; the flags guard every read
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[w_ptr_q] <= w_data;
    end

    assign r_data = mem_q[r_ptr_q];
    assign empty  = empty_q;
    assign full   = full_q;

endmodule

// File: rtl/uart_cfg.sv
// Configurable UART: runtime baud divisor, selectable parity, TX/RX FIFOs.
// Ports: clk, reset (sync, active-high); dvsr (tick period), par_mode;
//        TX side wr_uart/w_data/tx_full/tx; RX side rx/rd_uart/r_data/
//        r_perr/r_ferr/rx_empty; clr_err/err_ovr (sticky overrun); tx_idle.
module uart_cfg
    import uart_pkg::*;
#(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int DVSR_BIT = 11,
    parameter int FIFO_W   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DVSR_BIT-1:0] dvsr,
    input  logic [1:0]          par_mode,
    input  logic                wr_uart,
    input  logic [DBIT-1:0]     w_data,
    output logic                tx_full,
    output logic                tx,
    input  logic                rx,
    input  logic                rd_uart,
    output logic [DBIT-1:0]     r_data,
    output logic                r_perr,
    output logic                r_ferr,
    output logic                rx_empty,
    input  logic                clr_err,
    output logic                err_ovr,
    output logic                tx_idle
);
    localparam int unsigned S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int unsigned N_W = $clog2(DBIT);
    localparam int unsigned RW  = DBIT + 2;

    // Baud generator
    logic [DVSR_BIT-1:0] cnt_q, cnt_d, eff_m1;
    logic                tick;

    // TX state
    uart_state_e     tx_st_q, tx_st_d;
    logic [S_W-1:0]  tx_s_q, tx_s_d;
    logic [N_W-1:0]  tx_n_q, tx_n_d;
    logic [DBIT-1:0] tx_b_q, tx_b_d;
    logic            tx_pen_q, tx_pen_d, tx_pbit_q, tx_pbit_d;
    logic            tx_q, tx_d, tx_pop, tx_empty;
    logic [DBIT-1:0] tx_dout;

    // RX state
    logic [2:0]      rx_sync_q, rx_sync_d;
    uart_state_e     rx_st_q, rx_st_d;
    logic [S_W-1:0]  rx_s_q, rx_s_d;
    logic [N_W-1:0]  rx_n_q, rx_n_d;
    logic [DBIT-1:0] rx_b_q, rx_b_d;
    logic            rx_pen_q, rx_pen_d, rx_podd_q, rx_podd_d;
    logic            rx_perr_q, rx_perr_d;
    logic            rx_s, rx_fall, rx_wr, rx_full;
    logic [RW-1:0]   rx_wdata, rx_dout;
    logic            ovr_q, ovr_d;

    // Divisor below 2 is treated as 2; a counter past the new limit wraps at once
    always_comb begin
        eff_m1 = (dvsr < DVSR_BIT'(2)) ? DVSR_BIT'(1) : dvsr - DVSR_BIT'(1);
        tick   = (cnt_q >= eff_m1);
        cnt_d  = tick ? '0 : cnt_q + DVSR_BIT'(1);
    end

    // TX FSM next state; tx_d is the line level for the following cycle
    always_comb begin
        tx_st_d   = tx_st_q;
        tx_s_d    = tx_s_q;
        tx_n_d    = tx_n_q;
        tx_b_d    = tx_b_q;
        tx_pen_d  = tx_pen_q;
        tx_pbit_d = tx_pbit_q;
        tx_d      = tx_q;
        tx_pop    = 1'b0;
        case (tx_st_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (tick && !tx_empty) begin
                    tx_st_d   = ST_START;
                    tx_s_d    = '0;
                    tx_b_d    = tx_dout;
                    tx_pen_d  = par_on(par_mode);
                    tx_pbit_d = (^tx_dout) ^ (par_mode == PAR_ODD);
                    tx_d      = 1'b0;
                end
            end
            ST_START: if (tick) begin
                if (tx_s_q == S_W'(15)) begin
                    tx_st_d = ST_DATA;
                    tx_s_d  = '0;
                    tx_n_d  = '0;
                    tx_d    = tx_b_q[0];
                end else tx_s_d = tx_s_q + S_W'(1);
            end
            ST_DATA: if (tick) begin
                if (tx_s_q == S_W'(15)) begin
                    tx_s_d = '0;
                    tx_b_d = tx_b_q >> 1;
                    if (tx_n_q == N_W'(DBIT - 1)) begin
                        tx_st_d = tx_pen_q ? ST_PARITY : ST_STOP;
                        tx_d    = tx_pen_q ? tx_pbit_q : 1'b1;
                    end else begin
                        tx_n_d = tx_n_q + N_W'(1);
                        tx_d   = tx_b_q[1];
                    end
                end else tx_s_d = tx_s_q + S_W'(1);
            end
            ST_PARITY: if (tick) begin
                if (tx_s_q == S_W'(15)) begin
                    tx_st_d = ST_STOP;
                    tx_s_d  = '0;
                    tx_d    = 1'b1;
                end else tx_s_d = tx_s_q + S_W'(1);
            end
            ST_STOP: if (tick) begin
                if (tx_s_q == S_W'(SB_TICK - 1)) begin
                    tx_st_d = ST_IDLE;
                    tx_pop  = 1'b1;
                    tx_d    = 1'b1;
                end else tx_s_d = tx_s_q + S_W'(1);
            end
            default: begin
                tx_st_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // RX FSM next state; rx is synchronised and edge-detected first
    always_comb begin
        rx_sync_d = {rx_sync_q[1:0], rx};
        rx_s      = rx_sync_q[1];
        rx_fall   = rx_sync_q[2] & ~rx_sync_q[1];
        rx_st_d   = rx_st_q;
        rx_s_d    = rx_s_q;
        rx_n_d    = rx_n_q;
        rx_b_d    = rx_b_q;
        rx_pen_d  = rx_pen_q;
        rx_podd_d = rx_podd_q;
        rx_perr_d = rx_perr_q;
        rx_wr     = 1'b0;
        rx_wdata  = '0;
        case (rx_st_q)
            ST_IDLE: if (rx_fall) begin
                rx_st_d   = ST_START;
                rx_s_d    = '0;
                rx_pen_d  = par_on(par_mode);
                rx_podd_d = (par_mode == PAR_ODD);
                rx_perr_d = 1'b0;
            end
            ST_START: if (tick) begin
                if (rx_s_q == S_W'(7)) begin
                    // a line back high at mid-start is a glitch
                    rx_st_d = rx_s ? ST_IDLE : ST_DATA;
                    rx_s_d  = '0;
                    rx_n_d  = '0;
                end else rx_s_d = rx_s_q + S_W'(1);
            end
            ST_DATA: if (tick) begin
                if (rx_s_q == S_W'(15)) begin
                    rx_s_d = '0;
                    rx_b_d = {rx_s, rx_b_q[DBIT-1:1]};
                    if (rx_n_q == N_W'(DBIT - 1))
                        rx_st_d = rx_pen_q ? ST_PARITY : ST_STOP;
                    else
                        rx_n_d = rx_n_q + N_W'(1);
                end else rx_s_d = rx_s_q + S_W'(1);
            end
            ST_PARITY: if (tick) begin
                if (rx_s_q == S_W'(15)) begin
                    rx_st_d   = ST_STOP;
                    rx_s_d    = '0;
                    rx_perr_d = rx_s ^ (^rx_b_q) ^ rx_podd_q;
                end else rx_s_d = rx_s_q + S_W'(1);
            end
            ST_STOP: if (tick) begin
                if (rx_s_q == S_W'(15)) begin
                    rx_st_d  = ST_IDLE;
                    rx_wr    = 1'b1;
                    rx_wdata = {~rx_s, rx_perr_q, rx_b_q};
                end else rx_s_d = rx_s_q + S_W'(1);
            end
            default: rx_st_d = ST_IDLE;
        endcase
    end

    // Overrun only when the write is really dropped (no read alongside it)
    always_comb begin
        ovr_d = (rx_wr & rx_full & ~rd_uart) | (ovr_q & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            tx_st_q   <= ST_IDLE;
            tx_s_q    <= '0;
            tx_n_q    <= '0;
            tx_b_q    <= '0;
            tx_pen_q  <= 1'b0;
            tx_pbit_q <= 1'b0;
            tx_q      <= 1'b1;
            rx_sync_q <= 3'b111;
            rx_st_q   <= ST_IDLE;
            rx_s_q    <= '0;
            rx_n_q    <= '0;
            rx_b_q    <= '0;
            rx_pen_q  <= 1'b0;
            rx_podd_q <= 1'b0;
            rx_perr_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tx_st_q   <= tx_st_d;
            tx_s_q    <= tx_s_d;
            tx_n_q    <= tx_n_d;
            tx_b_q    <= tx_b_d;
            tx_pen_q  <= tx_pen_d;
            tx_pbit_q <= tx_pbit_d;
            tx_q      <= tx_d;
            rx_sync_q <= rx_sync_d;
            rx_st_q   <= rx_st_d;
            rx_s_q    <= rx_s_d;
            rx_n_q    <= rx_n_d;
            rx_b_q    <= rx_b_d;
            rx_pen_q  <= rx_pen_d;
            rx_podd_q <= rx_podd_d;
            rx_perr_q <= rx_perr_d;
            ovr_q     <= ovr_d;
        end
    end

    fifo #(.DATA_W(DBIT), .ADDR_W(FIFO_W)) u_tx_fifo (
        .clk    (clk),
        .reset  (reset),
        .rd     (tx_pop),
        .wr     (wr_uart),
        .w_data (w_data),
        .empty  (tx_empty),
        .full   (tx_full),
        .r_data (tx_dout)
    );

    fifo #(.DATA_W(RW), .ADDR_W(FIFO_W)) u_rx_fifo (
        .clk    (clk),
        .reset  (reset),
        .rd     (rd_uart),
        .wr     (rx_wr),
        .w_data (rx_wdata),
        .empty  (rx_empty),
        .full   (rx_full),
        .r_data (rx_dout)
    );

    // Head word is masked while empty so stale storage never shows
    assign tx      = tx_q;
    assign tx_idle = tx_empty & (tx_st_q == ST_IDLE);
    assign r_data  = rx_empty ? '0 : rx_dout[DBIT-1:0];
    assign r_perr  = ~rx_empty & rx_dout[DBIT];
    assign r_ferr  = ~rx_empty & rx_dout[DBIT+1];
    assign err_ovr = ovr_q;

endmodule

// File: tb/tb_uart_cfg.sv
// Self-checking bench for uart_cfg: line timing, loopback and direct RX
// frames, with received words checked against a queue of expected words.
module tb_uart_cfg;
    import uart_pkg::*;

    localparam int BIT4 = 64;   // cycles per bit at dvsr=4

    logic        clk = 1'b0;
    logic        reset, wr_uart, rd_uart, clr_err, loop_en, rx_drv, rx_line;
    logic [10:0] dvsr;
    logic [1:0]  par_mode;
    logic [7:0]  w_data, r_data;
    logic        tx_full, tx, r_perr, r_ferr, rx_empty, err_ovr, tx_idle;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [9:0]  exp_q[$];

    always #5 clk = ~clk;
    assign rx_line = loop_en ? tx : rx_drv;

    uart_cfg #(.DBIT(8), .SB_TICK(16), .DVSR_BIT(11), .FIFO_W(2)) dut (
        .clk(clk), .reset(reset), .dvsr(dvsr), .par_mode(par_mode),
        .wr_uart(wr_uart), .w_data(w_data), .tx_full(tx_full), .tx(tx),
        .rx(rx_line), .rd_uart(rd_uart), .r_data(r_data), .r_perr(r_perr),
        .r_ferr(r_ferr), .rx_empty(rx_empty), .clr_err(clr_err),
        .err_ovr(err_ovr), .tx_idle(tx_idle)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic par_model(input logic [7:0] d, input logic [1:0] m);
        return (m == PAR_ODD) ? ~(^d) : (^d);
    endfunction

    task automatic push_tx(input logic [7:0] d);
        w_data = d; wr_uart = 1'b1; step(1); wr_uart = 1'b0;
    endtask

    task automatic wait_tx(input logic lvl, input int bound, output logic ok);
        for (int i = 0; i < bound && tx !== lvl; i++) step(1);
        ok = (tx === lvl);
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound && tx_idle !== 1'b1; i++) step(1);
    endtask

    task automatic low_run(output int len);
        len = 0;
        while (tx === 1'b0 && len < 5000) begin len++; step(1); end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic with_par,
                              input logic pbit, input logic stop_val);
        rx_drv = 1'b0; step(BIT4);
        for (int i = 0; i < 8; i++) begin rx_drv = d[i]; step(BIT4); end
        if (with_par) begin rx_drv = pbit; step(BIT4); end
        rx_drv = stop_val; step(BIT4);
        rx_drv = 1'b1; step(2 * BIT4);
    endtask

    // Pop every expected word from the RX FIFO, in order
    task automatic drain_rx(input string tag);
        logic [9:0] exp_w, got_w;
        while (exp_q.size() > 0) begin
            for (int i = 0; i < 3000 && rx_empty !== 1'b0; i++) step(1);
            exp_w = exp_q.pop_front();
            got_w = {r_ferr, r_perr, r_data};
            n_checks++;
            if (rx_empty !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_rx_timeout: rx_empty=%b required 0 for word %h", tag, rx_empty, exp_w);
            end else begin
                if (got_w !== exp_w) begin
                    n_fail++;
                    $display("FAIL %s_rx_word: got {ferr,perr,data}=%h required %h", tag, got_w, exp_w);
                end
                rd_uart = 1'b1; step(1); rd_uart = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; step(3); reset = 1'b0; step(1);
        n_checks++; if (tx !== 1'b1)       begin n_fail++; $display("FAIL reset_tx: got %b required 1", tx); end
        n_checks++; if (tx_full !== 1'b0)  begin n_fail++; $display("FAIL reset_tx_full: got %b required 0", tx_full); end
        n_checks++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL reset_rx_empty: got %b required 1", rx_empty); end
        n_checks++; if (tx_idle !== 1'b1)  begin n_fail++; $display("FAIL reset_tx_idle: got %b required 1", tx_idle); end
        n_checks++; if ({r_perr, r_ferr} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b required 00", {r_perr, r_ferr}); end
        n_checks++; if (err_ovr !== 1'b0)  begin n_fail++; $display("FAIL reset_err_ovr: got %b required 0", err_ovr); end
    endtask

    // 0x55 at dvsr=27: 432-cycle start, LSB-first data, stop high
    task automatic test_tx_frame();
        logic [7:0] d;
        logic       ok;
        int         len;
        d = 8'h55; loop_en = 1'b1; dvsr = 11'd27; par_mode = PAR_NONE;
        push_tx(d); exp_q.push_back({2'b00, d});
        wait_tx(1'b0, 1000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL tx_start_seen: tx=%b required 0", tx); end
        low_run(len);
        n_checks++; if (len != 432) begin n_fail++; $display("FAIL tx_start_len: got %0d cycles required 432", len); end
        step(216);
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (tx !== d[k]) begin n_fail++; $display("FAIL tx_bit%0d: got %b required %b", k, tx, d[k]); end
            step(432);
        end
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL tx_stop: got %b required 1", tx); end
        wait_idle(1000);
        n_checks++; if (tx_idle !== 1'b1) begin n_fail++; $display("FAIL tx_idle_after: got %b required 1", tx_idle); end
        drain_rx("tx_frame");
    endtask

    // Even-parity loopback of 0xA3, parity bit checked on the line
    task automatic test_parity_loopback();
        logic ok;
        loop_en = 1'b1; dvsr = 11'd4; par_mode = PAR_EVEN;
        push_tx(8'hA3); exp_q.push_back({2'b00, 8'hA3});
        wait_tx(1'b0, 200, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL par_start_seen: tx=%b required 0", tx); end
        step(9 * BIT4 + BIT4 / 2);
        n_checks++;
        if (tx !== par_model(8'hA3, PAR_EVEN)) begin
            n_fail++; $display("FAIL par_line_bit: got %b required %b", tx, par_model(8'hA3, PAR_EVEN));
        end
        wait_idle(2000);
        drain_rx("parity");
    endtask

    // Directly driven frames with good parity, bad parity and bad stop bit
    task automatic test_rx_errors();
        logic good;
        loop_en = 1'b0; rx_drv = 1'b1; dvsr = 11'd4; par_mode = PAR_ODD;
        good = par_model(8'h0F, PAR_ODD);
        send_frame(8'h0F, 1'b1, good, 1'b1);  exp_q.push_back({1'b0, 1'b0, 8'h0F});
        send_frame(8'h0F, 1'b1, ~good, 1'b1); exp_q.push_back({1'b0, 1'b1, 8'h0F});
        send_frame(8'h0F, 1'b1, ~good, 1'b0); exp_q.push_back({1'b1, 1'b1, 8'h0F});
        drain_rx("rx_err");
    endtask

    // Five frames into a four-deep FIFO, then clear the sticky flag
    task automatic test_overrun();
        logic [7:0] d;
        loop_en = 1'b0; rx_drv = 1'b1; dvsr = 11'd4; par_mode = PAR_NONE;
        for (int i = 0; i < 5; i++) begin
            d = 8'(17 * (i + 1));
            send_frame(d, 1'b0, 1'b0, 1'b1);
            if (i < 4) exp_q.push_back({2'b00, d});
            if (i == 3) begin
                n_checks++; if (err_ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_early: got %b required 0", err_ovr); end
            end
        end
        n_checks++; if (err_ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b required 1", err_ovr); end
        clr_err = 1'b1; step(1); clr_err = 1'b0;
        n_checks++; if (err_ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b required 0", err_ovr); end
        drain_rx("overrun");
        n_checks++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL ovr_dropped: rx_empty=%b required 1", rx_empty); end
    endtask

    // Fill the TX FIFO, a fifth write is ignored
    task automatic test_back_to_back();
        loop_en = 1'b1; rx_drv = 1'b1; dvsr = 11'd4; par_mode = PAR_NONE;
        for (int i = 0; i < 4; i++) begin
            push_tx(8'(8'hA1 + i)); exp_q.push_back({2'b00, 8'(8'hA1 + i)});
        end
        n_checks++; if (tx_full !== 1'b1) begin n_fail++; $display("FAIL b2b_full: got %b required 1", tx_full); end
        push_tx(8'hEE);
        wait_idle(4000);
        n_checks++; if (tx_idle !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: got %b required 1", tx_idle); end
        step(10);
        drain_rx("b2b");
        n_checks++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL b2b_extra: rx_empty=%b required 1", rx_empty); end
    endtask

    // Divisor change mid-frame; the next frame runs at 208-cycle bits
    task automatic test_dvsr_change();
        logic ok;
        int   len;
        loop_en = 1'b1; dvsr = 11'd27; par_mode = PAR_NONE;
        push_tx(8'h00); exp_q.push_back({2'b00, 8'h00});
        wait_tx(1'b0, 1000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL dv_start_seen: tx=%b required 0", tx); end
        step(2000);
        dvsr = 11'd13;
        push_tx(8'h55); exp_q.push_back({2'b00, 8'h55});
        wait_tx(1'b1, 5000, ok);
        wait_tx(1'b0, 2000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL dv_second_start: tx=%b required 0", tx); end
        low_run(len);
        n_checks++; if (len != 208) begin n_fail++; $display("FAIL dv_start_len: got %0d cycles required 208", len); end
        wait_idle(4000);
        step(10);
        drain_rx("dvsr");
    endtask

    // Reset in the middle of a loopback data bit
    task automatic test_reset_mid();
        logic ok;
        loop_en = 1'b1; dvsr = 11'd4; par_mode = PAR_NONE;
        push_tx(8'h3C);
        wait_tx(1'b0, 200, ok);
        step(3 * BIT4 + 20);
        reset = 1'b1; step(1);
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_mid_tx: got %b required 1", tx); end
        n_checks++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL rst_mid_rx_empty: got %b required 1", rx_empty); end
        reset = 1'b0;
        step(1500);
        n_checks++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL rst_mid_no_word: rx_empty=%b required 1", rx_empty); end
        n_checks++; if ({tx_idle, tx} !== 2'b11) begin n_fail++; $display("FAIL rst_mid_idle: {tx_idle,tx}=%b required 11", {tx_idle, tx}); end
    endtask

    initial begin
        reset = 1'b1; wr_uart = 1'b0; rd_uart = 1'b0; clr_err = 1'b0;
        loop_en = 1'b1; rx_drv = 1'b1; dvsr = 11'd27; par_mode = PAR_NONE;
        w_data = 8'h00;
        test_reset();
        test_tx_frame();
        test_parity_loopback();
        test_rx_errors();
        test_overrun();
        test_back_to_back();
        test_dvsr_change();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
